store_narrow: RTL and testbench

STORE_NARROW -- requirements
Module: store_narrow

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_lane_gen.sv | 43 ++++
 rtl/store_narrow.sv | 155 +++++++++++++++
 tb/tb_store_narrow.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared definitions for the narrow-store path: size encodings, FSM states
// and lane count.
package store_pkg;

   localparam int unsigned NUM_LANES = 4;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_e;

   // Only the 11 encoding is rejected; every other size maps to 1/2/4 bytes.
   function automatic logic size_legal(input logic [1:0] sz);
      return sz != SZ_ILL;
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: builds the 8-bit byte mask and the 64-bit
// lane-shifted data for a store starting at byte offset off_i. The upper
// half of both outputs is the spill into the next word.
module store_lane_gen
   import store_pkg::*;
(
   input  logic [1:0]               off_i,
   input  logic [1:0]               size_i,
   input  logic [31:0]              data_i,
   output logic [2*NUM_LANES-1:0]   mask_o,
   output logic [63:0]              shifted_o
);

   logic [7:0]  base_mask;
   logic [31:0] trunc_data;

   // Truncate to the store width, then shift mask and data into lane position.
   always_comb begin
      base_mask  = 8'h00;
      trunc_data = 32'h0000_0000;
      case (size_i)
         SZ_BYTE: begin
            base_mask  = 8'h01;
            trunc_data = {24'h0, data_i[7:0]};
         end
         SZ_HALF: begin
            base_mask  = 8'h03;
            trunc_data = {16'h0, data_i[15:0]};
         end
         SZ_WORD: begin
            base_mask  = 8'h0F;
            trunc_data = data_i;
         end
         default: begin
            base_mask  = 8'h00;
            trunc_data = 32'h0000_0000;
         end
      endcase
      mask_o    = base_mask << off_i;
      shifted_o = {32'h0000_0000, trunc_data} << {off_i, 3'b000};
   end

endmodule

// File: rtl/store_narrow.sv
// Narrow store unit: converts SB/SH/SW requests at any byte address into one
// or two word-aligned, byte-enabled memory beats (two when the store crosses
// a word boundary). All memory-side outputs are registered and held until
// acknowledged.
module store_narrow
   import store_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        st_valid_i,
   output logic        st_ready_o,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  st_size_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_ack_i,
   output logic        done_o,
   output logic        err_o
);

   state_e      state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [3:0]  hi_be_q, hi_be_d;       // second-beat enables; nonzero means split
   logic [31:0] hi_wdata_q, hi_wdata_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        accept;
   logic        legal;
   logic [7:0]  lane_mask;
   logic [63:0] lane_data;

   store_lane_gen u_lane_gen (
      .off_i     (st_addr_i[1:0]),
      .size_i    (st_size_i),
      .data_i    (st_data_i),
      .mask_o    (lane_mask),
      .shifted_o (lane_data)
   );

   // Ready is gated by reset so it reads 0 while rst_i is low and 1 right after.
   assign st_ready_o = rst_i && (state_q == ST_IDLE);
   assign accept     = st_valid_i && st_ready_o;
   assign legal      = size_legal(st_size_i);

   // State and output registers; reset clears everything at once (aborts a beat).
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_be_q    <= 4'h0;
         hi_be_q     <= 4'h0;
         hi_wdata_q  <= 32'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         hi_be_q     <= hi_be_d;
         hi_wdata_q  <= hi_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state: a beat advances only on ack; BEAT1 is entered only for splits.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept && legal) state_d = ST_BEAT0;
         ST_BEAT0: if (mem_ack_i) state_d = (hi_be_q != 4'h0) ? ST_BEAT1 : ST_IDLE;
         ST_BEAT1: if (mem_ack_i) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output next values: load beat 0 on accept, swap in beat 1 on split ack,
   // clear and pulse done on the final ack.
   always_comb begin
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      hi_be_d     = hi_be_q;
      hi_wdata_d  = hi_wdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (legal) begin
                  mem_req_d   = 1'b1;
                  mem_addr_d  = {st_addr_i[31:2], 2'b00};
                  mem_be_d    = lane_mask[3:0];
                  mem_wdata_d = lane_data[31:0];
                  hi_be_d     = lane_mask[7:4];
                  hi_wdata_d  = lane_data[63:32];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_BEAT0: begin
            if (mem_ack_i) begin
               if (hi_be_q != 4'h0) begin
                  // Natural 32-bit wrap takes 0xFFFFFFFC to 0x00000000.
                  mem_addr_d  = mem_addr_q + 32'd4;
                  mem_be_d    = hi_be_q;
                  mem_wdata_d = hi_wdata_q;
                  hi_be_d     = 4'h0;
                  hi_wdata_d  = 32'h0;
               end else begin
                  mem_req_d   = 1'b0;
                  mem_addr_d  = 32'h0;
                  mem_wdata_d = 32'h0;
                  mem_be_d    = 4'h0;
                  done_d      = 1'b1;
               end
            end
         end
         ST_BEAT1: begin
            if (mem_ack_i) begin
               mem_req_d   = 1'b0;
               mem_addr_d  = 32'h0;
               mem_wdata_d = 32'h0;
               mem_be_d    = 4'h0;
               done_d      = 1'b1;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            mem_be_d  = 4'h0;
         end
      endcase
   end

   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_store_narrow.sv
// Testbench for store_narrow: table of stores with expected beats pushed to
// a scoreboard queue, plus hand-written illegal-size and reset-abort sequences.
module tb_store_narrow;
   import store_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [31:0] st_addr_i;
   logic [31:0] st_data_i;
   logic [1:0]  st_size_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ack_i;
   logic        done_o;
   logic        err_o;

   store_narrow dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .st_valid_i  (st_valid_i),
      .st_ready_o  (st_ready_o),
      .st_addr_i   (st_addr_i),
      .st_data_i   (st_data_i),
      .st_size_i   (st_size_i),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_ack_i   (mem_ack_i),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [7:0]  delay;
      logic        split;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] w0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] w1;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } beat_t;

   beat_t exp_q[$];
   vec_t  vecs[12];

   int tests    = 0;
   int fails    = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int exp_done = 0;
   int exp_err  = 0;

   function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input logic [7:0] delay,
                               input logic split,
                               input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] w0,
                               input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] w1);
      vec_t v;
      v.addr = addr; v.data = data; v.size = size; v.delay = delay; v.split = split;
      v.a0 = a0; v.be0 = be0; v.w0 = w0;
      v.a1 = a1; v.be1 = be1; v.w1 = w1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Pulse counters and per-cycle invariants, sampled away from the rising edge.
   always @(negedge clk_i) begin
      if (done_o === 1'b1) done_cnt++;
      if (err_o === 1'b1) err_cnt++;
      if (rst_i === 1'b1) begin
         tests++;
         if ((done_o === 1'b1 && err_o === 1'b1) || mem_addr_o[1:0] !== 2'b00) begin
            fails++;
            $display("FAIL invariant: done=%b err=%b addr=0x%08h", done_o, err_o, mem_addr_o);
         end
      end
   end

   // Issue one store from an idle cycle, then ack each expected beat after v.delay wait cycles.
   task automatic do_store(input vec_t v);
      beat_t b;
      check("ready_before_accept", {31'b0, st_ready_o}, 32'd1);
      st_valid_i = 1'b1;
      st_addr_i  = v.addr;
      st_data_i  = v.data;
      st_size_i  = v.size;
      b.addr = v.a0; b.be = v.be0; b.wdata = v.w0;
      exp_q.push_back(b);
      if (v.split) begin
         b.addr = v.a1; b.be = v.be1; b.wdata = v.w1;
         exp_q.push_back(b);
      end
      @(posedge clk_i); #1;
      // Held junk request while busy must be ignored (an illegal size would show up as err).
      st_valid_i = 1'b1;
      st_addr_i  = 32'h0BAD_0001;
      st_data_i  = $urandom;
      st_size_i  = SZ_ILL;
      check("err_after_legal", {31'b0, err_o}, 32'd0);
      while (exp_q.size() > 0) begin
         b = exp_q[0];
         check("mem_req", {31'b0, mem_req_o}, 32'd1);
         for (int d = 0; d < int'(v.delay); d++) begin
            check("hold_addr", mem_addr_o, b.addr);
            check("hold_be", {28'b0, mem_be_o}, {28'b0, b.be});
            check("hold_wdata", mem_wdata_o, b.wdata);
            @(posedge clk_i); #1;
         end
         mem_ack_i = 1'b1;
         check("beat_addr", mem_addr_o, b.addr);
         check("beat_be", {28'b0, mem_be_o}, {28'b0, b.be});
         check("beat_wdata", mem_wdata_o, b.wdata);
         $display("[TB] beat addr=0x%08h be=%b wdata=0x%08h", mem_addr_o, mem_be_o, mem_wdata_o);
         @(posedge clk_i); #1;
         mem_ack_i = 1'b0;
         void'(exp_q.pop_front());
      end
      st_valid_i = 1'b0;
      check("done_pulse", {31'b0, done_o}, 32'd1);
      check("err_with_done", {31'b0, err_o}, 32'd0);
      check("req_after_done", {31'b0, mem_req_o}, 32'd0);
      check("be_after_done", {28'b0, mem_be_o}, 32'd0);
      check("ready_after_done", {31'b0, st_ready_o}, 32'd1);
      exp_done++;
      $display("[TB] store addr=0x%08h size=%b done", v.addr, v.size);
   endtask

   initial begin
      int done_before;
      rst_i      = 1'b0;
      st_valid_i = 1'b0;
      st_addr_i  = 32'h0;
      st_data_i  = 32'h0;
      st_size_i  = 2'b00;
      mem_ack_i  = 1'b0;

      vecs[0]  = mk(32'h0000_0100, 32'hDEAD_BEEF, SZ_WORD, 8'd0, 1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'h0, 32'h0);
      vecs[1]  = mk(32'h0000_0203, 32'h1234_56AB, SZ_BYTE, 8'd0, 1'b0, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 32'h0, 4'h0, 32'h0);
      vecs[2]  = mk(32'h0000_0307, 32'hFFFF_1234, SZ_HALF, 8'd3, 1'b1, 32'h0000_0304, 4'b1000, 32'h3400_0000, 32'h0000_0308, 4'b0001, 32'h0000_0012);
      vecs[3]  = mk(32'hFFFF_FFFE, 32'hAABB_CCDD, SZ_WORD, 8'd1, 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000, 32'h0000_0000, 4'b0011, 32'h0000_AABB);
      vecs[4]  = mk(32'h0000_0001, 32'hFFFF_FF5A, SZ_BYTE, 8'd0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 32'h0, 4'h0, 32'h0);
      vecs[5]  = mk(32'h0000_0002, 32'h0000_00C3, SZ_BYTE, 8'd2, 1'b0, 32'h0000_0000, 4'b0100, 32'h00C3_0000, 32'h0, 4'h0, 32'h0);
      vecs[6]  = mk(32'h0000_0102, 32'hCAFE_BEEF, SZ_HALF, 8'd0, 1'b0, 32'h0000_0100, 4'b1100, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0);
      vecs[7]  = mk(32'h0000_0101, 32'h0000_A55A, SZ_HALF, 8'd1, 1'b0, 32'h0000_0100, 4'b0110, 32'h00A5_5A00, 32'h0, 4'h0, 32'h0);
      vecs[8]  = mk(32'h0000_0000, 32'h8765_4321, SZ_HALF, 8'd0, 1'b0, 32'h0000_0000, 4'b0011, 32'h0000_4321, 32'h0, 4'h0, 32'h0);
      vecs[9]  = mk(32'h0000_0401, 32'h1122_3344, SZ_WORD, 8'd0, 1'b1, 32'h0000_0400, 4'b1110, 32'h2233_4400, 32'h0000_0404, 4'b0001, 32'h0000_0011);
      vecs[10] = mk(32'h0000_0503, 32'hA1B2_C3D4, SZ_WORD, 8'd2, 1'b1, 32'h0000_0500, 4'b1000, 32'hD400_0000, 32'h0000_0504, 4'b0111, 32'h00A1_B2C3);
      vecs[11] = mk(32'h0000_07FC, 32'h0000_00EE, SZ_BYTE, 8'd1, 1'b0, 32'h0000_07FC, 4'b0001, 32'h0000_00EE, 32'h0, 4'h0, 32'h0);

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", {31'b0, st_ready_o}, 32'd0);
      check("rst_req", {31'b0, mem_req_o}, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      check("rst_be", {28'b0, mem_be_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      rst_i = 1'b1;
      #1;
      check("ready_after_rst", {31'b0, st_ready_o}, 32'd1);

      // Table of stores
      for (int i = 0; i < 12; i++) do_store(vecs[i]);

      // Illegal size: err pulse, no memory access, then SB accepted in the err cycle
      st_valid_i = 1'b1;
      st_addr_i  = 32'h0000_0040;
      st_data_i  = 32'h1111_1111;
      st_size_i  = SZ_ILL;
      @(posedge clk_i); #1;
      st_valid_i = 1'b0;
      exp_err++;
      check("ill_err", {31'b0, err_o}, 32'd1);
      check("ill_done", {31'b0, done_o}, 32'd0);
      check("ill_req", {31'b0, mem_req_o}, 32'd0);
      $display("[TB] illegal size err=%b req=%b", err_o, mem_req_o);
      do_store(mk(32'h0000_0041, 32'h0000_0077, SZ_BYTE, 8'd0, 1'b0, 32'h0000_0040, 4'b0010, 32'h0000_7700, 32'h0, 4'h0, 32'h0));

      // Reset during BEAT1 of a split word store
      st_valid_i = 1'b1;
      st_addr_i  = 32'h0000_0602;
      st_data_i  = 32'h0102_0304;
      st_size_i  = SZ_WORD;
      @(posedge clk_i); #1;
      st_valid_i = 1'b0;
      check("abort_b0_req", {31'b0, mem_req_o}, 32'd1);
      check("abort_b0_addr", mem_addr_o, 32'h0000_0600);
      check("abort_b0_be", {28'b0, mem_be_o}, 32'h0000_000C);
      check("abort_b0_wdata", mem_wdata_o, 32'h0304_0000);
      mem_ack_i = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      check("abort_b1_addr", mem_addr_o, 32'h0000_0604);
      check("abort_b1_be", {28'b0, mem_be_o}, 32'h0000_0003);
      check("abort_b1_wdata", mem_wdata_o, 32'h0000_0102);
      done_before = done_cnt;
      #2;
      rst_i = 1'b0;
      #1;
      check("abort_req", {31'b0, mem_req_o}, 32'd0);
      check("abort_addr", mem_addr_o, 32'd0);
      check("abort_wdata", mem_wdata_o, 32'd0);
      check("abort_be", {28'b0, mem_be_o}, 32'd0);
      check("abort_ready", {31'b0, st_ready_o}, 32'd0);
      check("abort_done", {31'b0, done_o}, 32'd0);
      $display("[TB] reset abort req=%b be=%b", mem_req_o, mem_be_o);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      check("abort_ready_rel", {31'b0, st_ready_o}, 32'd1);
      check("abort_no_done", done_cnt, done_before);
      do_store(mk(32'h0000_0000, 32'h55AA_33CC, SZ_WORD, 8'd1, 1'b0, 32'h0000_0000, 4'b1111, 32'h55AA_33CC, 32'h0, 4'h0, 32'h0));

      repeat (3) @(posedge clk_i);
      #1;
      check("done_count", done_cnt, exp_done);
      check("err_count", err_cnt, exp_err);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
